io_uart_in: RTL and testbench

IO_UART_IN -- requirements
Module: io_uart_in

---
 rtl/io_uart_in.sv | 107 ++++++++++
 tb/tb_io_uart_in.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_in.sv
// UART receive buffer: RX characters queue in a small FIFO and are drained via memory-mapped IO reads.
// The read path uses a daisy-chain: when this block has no registered read hit, it passes upstream read data through.
module io_uart_in #(
    parameter int          FIFO_AW  = 4,
    parameter logic [15:2] ADR_DATA = 14'h3008,
    parameter logic [15:2] ADR_STAT = 14'h3009,
    parameter logic [15:2] ADR_CTRL = 14'h300A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [15:2] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [15:2] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    input  logic [7:0]  uart_in_char,
    input  logic        uart_in_we,
    output logic        uart_in_full,
    output logic        rx_int
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovr_q, ovr_d, ien_q, ien_d, hit_q, hit_d, rx_int_q, rx_int_d;
    logic [31:0]        rd_q, rd_d;
    logic               full, empty, push, drop, pop;
    logic               unused_wdata;

    assign unused_wdata = ^{dma_io_wdata[31:3], dma_io_wdata[1]};

    assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        push     = uart_in_we & ~full;
        drop     = uart_in_we & full;
        pop      = dma_io_radr_en & (dma_io_radr == ADR_DATA) & ~empty;
        wptr_d   = wptr_q + FIFO_AW'(push);
        rptr_d   = rptr_q + FIFO_AW'(pop);
        count_d  = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        rx_int_d = ien_q & ~empty;
        // A dropped push sets overrun even if software clears it in the same cycle.
        ovr_d = ovr_q;
        if (drop)
            ovr_d = 1'b1;
        else if (dma_io_we && dma_io_wadr == ADR_STAT && dma_io_wdata[2])
            ovr_d = 1'b0;
        ien_d = ien_q;
        if (dma_io_we && dma_io_wadr == ADR_CTRL)
            ien_d = dma_io_wdata[0];
        hit_d = 1'b0;
        rd_d  = '0;
        if (dma_io_radr_en) begin
            case (dma_io_radr)
                ADR_DATA: begin
                    hit_d = 1'b1;
                    rd_d  = empty ? 32'h0 : {23'h0, 1'b1, mem[rptr_q]};
                end
                ADR_STAT: begin
                    hit_d = 1'b1;
                    rd_d  = (32'(count_q) << 8) | {29'h0, ovr_q, full, ~empty};
                end
                ADR_CTRL: begin
                    hit_d = 1'b1;
                    rd_d  = {31'h0, ien_q};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ien_q    <= 1'b0;
            hit_q    <= 1'b0;
            rd_q     <= '0;
            rx_int_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ien_q    <= ien_d;
            hit_q    <= hit_d;
            rd_q     <= rd_d;
            rx_int_q <= rx_int_d;
        end
    end

    // Storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr_q] <= uart_in_char;
    end

    assign uart_in_full = full;
    assign rx_int       = rx_int_q;
    assign dma_io_rdata = hit_q ? rd_q : dma_io_rdata_in;
endmodule

// File: tb/tb_io_uart_in.sv
// Directed bench for io_uart_in: a queue-based reference model checked every cycle, plus literal expectations.
module tb_io_uart_in;
    localparam logic [15:2] A_DATA = 14'h3008;
    localparam logic [15:2] A_STAT = 14'h3009;
    localparam logic [15:2] A_CTRL = 14'h300A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, radr_en, uwe;
    logic [15:2] wadr, radr;
    logic [31:0] wdata, rdata_in, rdata;
    logic [7:0]  uchar;
    logic        ufull, rxi;

    io_uart_in dut (
        .clk(clk), .rst_n(rst_n),
        .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
        .dma_io_radr(radr), .dma_io_radr_en(radr_en),
        .dma_io_rdata_in(rdata_in), .dma_io_rdata(rdata),
        .uart_in_char(uchar), .uart_in_we(uwe),
        .uart_in_full(ufull), .rx_int(rxi)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    bit chk_en = 0;

    byte unsigned mq[$];
    bit           m_ovr, m_ien, m_rx, m_hit;
    logic [31:0]  m_rd;

    function automatic void check32(string nm, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovr = 0; m_ien = 0; m_rx = 0; m_hit = 0; m_rd = '0;
    endtask

    task automatic model_step();
        int n;
        bit f, e;
        n = mq.size();
        f = (n == 16);
        e = (n == 0);
        m_hit = 0;
        m_rd  = '0;
        if (radr_en) begin
            if (radr == A_DATA) begin
                m_hit = 1;
                m_rd  = e ? 32'h0 : (32'h100 | 32'(mq[0]));
            end else if (radr == A_STAT) begin
                m_hit = 1;
                m_rd  = (32'(n) * 256) + (m_ovr ? 4 : 0) + (f ? 2 : 0) + (e ? 0 : 1);
            end else if (radr == A_CTRL) begin
                m_hit = 1;
                m_rd  = m_ien ? 32'h1 : 32'h0;
            end
        end
        m_rx = m_ien && !e;
        if (radr_en && radr == A_DATA && !e) void'(mq.pop_front());
        if (uwe && !f) mq.push_back(uchar);
        if (uwe && f) m_ovr = 1;
        else if (we && wadr == A_STAT && wdata[2]) m_ovr = 0;
        if (we && wadr == A_CTRL) m_ien = wdata[0];
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check32("rdata", rdata, m_hit ? m_rd : rdata_in);
            check32("full", {31'h0, ufull}, {31'h0, mq.size() == 16});
            check32("rx_int", {31'h0, rxi}, {31'h0, m_rx});
        end
    end

    task automatic clr();
        we = 0; radr_en = 0; uwe = 0;
        wadr = '0; radr = '0; wdata = '0; uchar = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        clr();
    endtask

    task automatic push(input logic [7:0] c);
        uwe = 1; uchar = c; tick();
    endtask

    task automatic rd(input logic [15:2] a);
        radr_en = 1; radr = a; tick();
    endtask

    task automatic wr(input logic [15:2] a, input logic [31:0] d);
        we = 1; wadr = a; wdata = d; tick();
    endtask

    task automatic expect_rd(string nm, input logic [31:0] e);
        @(negedge clk);
        check32(nm, rdata, e);
    endtask

    initial begin
        rst_n = 0;
        rdata_in = 32'hDEAD_BEEF;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        check32("rst_rdata", rdata, 32'hDEAD_BEEF);
        check32("rst_full", {31'h0, ufull}, 32'h0);
        check32("rst_rxint", {31'h0, rxi}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        rdata_in = 32'h0;

        // empty reads
        rd(A_DATA); expect_rd("empty_data", 32'h0);
        rd(A_STAT); expect_rd("empty_stat", 32'h0);

        // single char
        push(8'h41);
        rd(A_DATA); expect_rd("data_A", 32'h0000_0141);
        rd(A_STAT); expect_rd("stat_after_A", 32'h0);

        // ignored write to DATA, foreign address pass-through
        wr(A_DATA, 32'hFFFF_FFFF);
        rd(A_STAT); expect_rd("stat_after_wdata", 32'h0);
        rdata_in = 32'hCAFE_F00D;
        rd(14'h1234); expect_rd("foreign_passthru", 32'hCAFE_F00D);
        rdata_in = 32'h0;

        // fill and overrun
        for (int i = 0; i < 16; i++) push(8'(i));
        @(negedge clk);
        check32("full_after_16", {31'h0, ufull}, 32'h1);
        push(8'h10);
        rd(A_STAT); expect_rd("stat_overrun", 32'h0000_1007);
        uwe = 1; uchar = 8'h99; we = 1; wadr = A_STAT; wdata = 32'h4; tick();
        rd(A_STAT); expect_rd("ovr_set_wins", 32'h0000_1007);
        wr(A_STAT, 32'h4);
        rd(A_STAT); expect_rd("ovr_cleared", 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            rd(A_DATA); expect_rd("drain", 32'h100 + 32'(i));
        end
        rd(A_STAT); expect_rd("stat_drained", 32'h0);

        // steady-state push+pop with wrap
        push(8'h20); push(8'h21); push(8'h22);
        for (int i = 0; i < 40; i++) begin
            uwe = 1; uchar = 8'(8'h23 + i); radr_en = 1; radr = A_DATA; tick();
            expect_rd("pushpop", 32'h100 | 32'(8'h20 + i));
        end
        rd(A_STAT); expect_rd("stat_cnt3", 32'h0000_0301);
        for (int i = 0; i < 3; i++) begin
            rd(A_DATA); expect_rd("drain3", 32'h100 | 32'(8'h48 + i));
        end

        // interrupt
        wr(A_CTRL, 32'h1);
        rd(A_CTRL); expect_rd("ctrl_rd", 32'h1);
        push(8'h5A);
        @(negedge clk);
        check32("rxint_lag", {31'h0, rxi}, 32'h0);
        tick();
        @(negedge clk);
        check32("rxint_set", {31'h0, rxi}, 32'h1);
        rd(A_DATA);
        @(negedge clk);
        check32("rxint_hold", {31'h0, rxi}, 32'h1);
        tick();
        @(negedge clk);
        check32("rxint_clr", {31'h0, rxi}, 32'h0);
        rdata_in = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        check32("idle_passthru", rdata, 32'hDEAD_BEEF);

        // mid-operation reset
        push(8'h55); push(8'h66);
        rdata_in = 32'h1234_5678;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        check32("midrst_full", {31'h0, ufull}, 32'h0);
        check32("midrst_rdata", rdata, 32'h1234_5678);
        tick();
        rst_n = 1;
        push(8'h77);
        rd(A_DATA); expect_rd("post_rst_data", 32'h0000_0177);
        rd(A_STAT); expect_rd("post_rst_stat", 32'h0);
        rd(A_CTRL); expect_rd("post_rst_ctrl", 32'h0);
        tick();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
